// File: rtl/round_key_store_xor_if.sv
// Streaming handshake bundle for the round-key XOR stage: input side
// (state + round index) and output side (XORed state + round index).
interface round_key_store_xor_if #(
   parameter int DATA_W = 128
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_state;
   logic [3:0]        in_round;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_state;
   logic [3:0]        out_round;

   modport master (
      output in_valid, in_state, in_round, out_ready,
      input  in_ready, out_valid, out_state, out_round
   );

   modport slave (
      input  in_valid, in_state, in_round, out_ready,
      output in_ready, out_valid, out_state, out_round
   );
endinterface

// File: rtl/round_key_store_xor.sv
// Round-key bank (NR+1 entries) with a one-stage AddRoundKey datapath.
// Optional macro ARK_ZEROIZE_EN: key_clr wipes key data one entry per cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | normal operation; key writes and transfers allowed
// S_ZERO | zeroizing entries 0..NR, one per cycle; busy=1, in_ready=0
module round_key_store_xor #(
   parameter int NR     = 10,
   parameter int DATA_W = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                key_wr_en,
   input  logic [3:0]          key_wr_idx,
   input  logic [DATA_W-1:0]   key_wr_data,
   input  logic                key_clr,
   output logic                keys_ready,
   output logic                busy,
   output logic                err_round,
   input  logic                err_clr,
   round_key_store_xor_if.slave dp
);

   localparam logic [3:0] NR_IDX = 4'(NR);

   typedef enum logic {S_IDLE, S_ZERO} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              zero_we;
   logic [3:0]        zcnt;
   logic [3:0]        z_idx;
   logic              rdy_q;
   logic [NR:0]       loaded;
   logic [DATA_W-1:0] bank [0:NR];
   logic [DATA_W-1:0] rd_key;
   logic              rd_loaded;
   logic              round_ok;
   logic              xfer;
   logic              clr_map;
   logic              wr_ok;

   // rdy_q keeps in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   assign dp.in_ready = rdy_q && !busy && (!dp.out_valid || dp.out_ready);
   assign xfer        = dp.in_valid && dp.in_ready;
   assign round_ok    = (dp.in_round <= NR_IDX);
   assign clr_map     = key_clr && (state == S_IDLE);
   // a write coinciding with key_clr is dropped so the clear is never undone
   assign wr_ok       = key_wr_en && (key_wr_idx <= NR_IDX) && !busy && !clr_map;
   assign z_idx       = NR_IDX - zcnt;
   assign keys_ready  = (&loaded) && !busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
`ifdef ARK_ZEROIZE_EN
            if (key_clr) state_nxt = S_ZERO;
`endif
         end
         S_ZERO: if (zcnt == 4'd0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      zero_we = 1'b0;
      if (state == S_ZERO) begin
         busy    = 1'b1;
         zero_we = 1'b1;
      end
   end

   // zeroize timer: counts NR..0, entry index walks 0..NR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                zcnt <= 4'd0;
      else if (state == S_IDLE)  zcnt <= NR_IDX;
      else if (zcnt != 4'd0)     zcnt <= zcnt - 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= NR; i++) bank[i] <= '0;
      end else begin
         for (int i = 0; i <= NR; i++) begin
            if (zero_we && (z_idx == 4'(i)))
               bank[i] <= '0;
            else if (wr_ok && (key_wr_idx == 4'(i)))
               bank[i] <= key_wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loaded <= '0;
      end else if (clr_map) begin
         loaded <= '0;
      end else begin
         for (int i = 0; i <= NR; i++)
            if (wr_ok && (key_wr_idx == 4'(i))) loaded[i] <= 1'b1;
      end
   end

   // read sees the pre-edge bank, so a same-cycle write applies next cycle
   always_comb begin
      rd_key    = '0;
      rd_loaded = 1'b0;
      for (int i = 0; i <= NR; i++) begin
         if (dp.in_round == 4'(i)) begin
            rd_key    = bank[i];
            rd_loaded = loaded[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp.out_valid <= 1'b0;
         dp.out_state <= '0;
         dp.out_round <= 4'd0;
      end else if (xfer) begin
         dp.out_valid <= 1'b1;
         dp.out_round <= dp.in_round;
         dp.out_state <= round_ok ? (dp.in_state ^ rd_key) : dp.in_state;
      end else if (dp.out_ready) begin
         dp.out_valid <= 1'b0;
      end
   end

   // out-of-range rounds never have a loaded entry, so one term covers both
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   err_round <= 1'b0;
      else if (xfer && !rd_loaded)  err_round <= 1'b1;
      else if (err_clr)             err_round <= 1'b0;
   end

endmodule

// File: tb/tb_round_key_store_xor.sv
// Directed testbench for round_key_store_xor; exercises the zeroize path
// when ARK_ZEROIZE_EN is defined and the bitmap-only clear otherwise.
module tb_round_key_store_xor;
   localparam int NR = 10;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          key_wr_en = 1'b0;
   logic [3:0]    key_wr_idx = 4'd0;
   logic [DW-1:0] key_wr_data = '0;
   logic          key_clr = 1'b0;
   logic          err_clr = 1'b0;
   logic          keys_ready;
   logic          busy;
   logic          err_round;

   int checks = 0;
   int errors = 0;

   localparam logic [DW-1:0] NEWK = 128'hffeeddccbbaa99887766554433221100;

   round_key_store_xor_if #(.DATA_W(DW)) dif ();

   round_key_store_xor #(.NR(NR), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_wr_en   (key_wr_en),
      .key_wr_idx  (key_wr_idx),
      .key_wr_data (key_wr_data),
      .key_clr     (key_clr),
      .keys_ready  (keys_ready),
      .busy        (busy),
      .err_round   (err_round),
      .err_clr     (err_clr),
      .dp          (dif)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk_key(input int i);
      logic [3:0] n;
      n = 4'(i);
      return {16{n, n}};
   endfunction

   function automatic logic [DW-1:0] mk_state(input int i);
      logic [15:0] h;
      h = 16'h1000 + 16'(i);
      return {8{h}};
   endfunction

   task automatic write_key(input int idx, input logic [DW-1:0] data);
      @(negedge clk);
      key_wr_en   = 1'b1;
      key_wr_idx  = 4'(idx);
      key_wr_data = data;
      @(negedge clk);
      key_wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({dif.in_ready, dif.out_valid, dif.out_round, err_round, busy, keys_ready} !== 9'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0",
                  {dif.in_ready, dif.out_valid, dif.out_round, err_round, busy, keys_ready});
      end
      checks++;
      if (dif.out_state !== '0) begin
         errors++;
         $display("FAIL reset_state: got %h expected 0", dif.out_state);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (dif.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: got %b expected 0", dif.in_ready);
      end
      @(negedge clk);
      checks++;
      if (dif.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_edge: got %b expected 1", dif.in_ready);
      end
   endtask

   task automatic test_single();
      write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
      dif.in_valid = 1'b1;
      dif.in_round = 4'd0;
      dif.in_state = 128'h00112233445566778899aabbccddeeff;
      @(negedge clk);
      dif.in_valid = 1'b0;
      checks++;
      if (dif.out_valid !== 1'b1 || dif.out_state !== 128'h00102030405060708090a0b0c0d0e0f0) begin
         errors++;
         $display("FAIL single_xor: got v=%b %h expected v=1 00102030405060708090a0b0c0d0e0f0",
                  dif.out_valid, dif.out_state);
      end
      checks++;
      if (dif.out_round !== 4'd0 || err_round !== 1'b0) begin
         errors++;
         $display("FAIL single_round: got round=%0d err=%b expected 0/0", dif.out_round, err_round);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < NR; i++) write_key(i, mk_key(i));
      write_key(11, mk_key(11));
      checks++;
      if (keys_ready !== 1'b0) begin
         errors++;
         $display("FAIL keys_ready_partial: got %b expected 0", keys_ready);
      end
      write_key(NR, mk_key(NR));
      checks++;
      if (keys_ready !== 1'b1) begin
         errors++;
         $display("FAIL keys_ready_full: got %b expected 1", keys_ready);
      end
      dif.in_valid = 1'b1;
      for (int i = 0; i <= NR; i++) begin
         checks++;
         if (dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready[%0d]: got %b expected 1", i, dif.in_ready);
         end
         dif.in_round = 4'(i);
         dif.in_state = mk_state(i);
         @(negedge clk);
         checks++;
         if (dif.out_valid !== 1'b1 || dif.out_round !== 4'(i) ||
             dif.out_state !== (mk_state(i) ^ mk_key(i))) begin
            errors++;
            $display("FAIL stream_out[%0d]: got v=%b r=%0d %h expected v=1 r=%0d %h", i,
                     dif.out_valid, dif.out_round, dif.out_state, i, mk_state(i) ^ mk_key(i));
         end
      end
      dif.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (dif.out_valid !== 1'b0 || err_round !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain: got v=%b err=%b expected 0/0", dif.out_valid, err_round);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] sa;
      logic [DW-1:0] sb;
      sa = {16{8'ha5}};
      sb = {16{8'h3c}};
      dif.out_ready = 1'b0;
      dif.in_valid  = 1'b1;
      dif.in_round  = 4'd1;
      dif.in_state  = sa;
      @(negedge clk);
      dif.in_round = 4'd2;
      dif.in_state = sb;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b1 || dif.out_round !== 4'd1 ||
             dif.out_state !== (sa ^ mk_key(1))) begin
            errors++;
            $display("FAIL stall[%0d]: got rdy=%b v=%b r=%0d %h expected rdy=0 v=1 r=1 %h", c,
                     dif.in_ready, dif.out_valid, dif.out_round, dif.out_state, sa ^ mk_key(1));
         end
         if (c < 2) @(negedge clk);
      end
      dif.out_ready = 1'b1;
      @(negedge clk);
      dif.in_valid = 1'b0;
      checks++;
      if (dif.out_valid !== 1'b1 || dif.out_round !== 4'd2 || dif.out_state !== (sb ^ mk_key(2))) begin
         errors++;
         $display("FAIL resume: got v=%b r=%0d %h expected v=1 r=2 %h",
                  dif.out_valid, dif.out_round, dif.out_state, sb ^ mk_key(2));
      end
      @(negedge clk);
      checks++;
      if (dif.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL no_duplicate: got v=%b expected 0", dif.out_valid);
      end
   endtask

   task automatic test_bad_round();
      logic [DW-1:0] sc;
      sc = 128'h0123456789abcdef0123456789abcdef;
      dif.in_valid = 1'b1;
      dif.in_round = 4'd11;
      dif.in_state = sc;
      @(negedge clk);
      dif.in_valid = 1'b0;
      checks++;
      if (dif.out_state !== sc || dif.out_round !== 4'd11 || err_round !== 1'b1) begin
         errors++;
         $display("FAIL bad_round: got r=%0d err=%b %h expected r=11 err=1 %h",
                  dif.out_round, err_round, dif.out_state, sc);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_round !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got %b expected 0", err_round);
      end
      dif.in_valid = 1'b1;
      err_clr = 1'b1;
      @(negedge clk);
      dif.in_valid = 1'b0;
      err_clr = 1'b0;
      checks++;
      if (err_round !== 1'b1) begin
         errors++;
         $display("FAIL err_set_wins: got %b expected 1", err_round);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_same_cycle();
      logic [DW-1:0] ss;
      ss = 128'hcafef00dcafef00dcafef00dcafef00d;
      key_wr_en    = 1'b1;
      key_wr_idx   = 4'd5;
      key_wr_data  = NEWK;
      dif.in_valid = 1'b1;
      dif.in_round = 4'd5;
      dif.in_state = ss;
      @(negedge clk);
      key_wr_en = 1'b0;
      checks++;
      if (dif.out_state !== (ss ^ mk_key(5))) begin
         errors++;
         $display("FAIL same_cycle_old: got %h expected %h", dif.out_state, ss ^ mk_key(5));
      end
      @(negedge clk);
      dif.in_valid = 1'b0;
      checks++;
      if (dif.out_state !== (ss ^ NEWK) || err_round !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_new: got err=%b %h expected err=0 %h", err_round, dif.out_state, ss ^ NEWK);
      end
   endtask

   task automatic test_zeroize();
      int cnt;
      logic [DW-1:0] kexp;
      cnt = 0;
      key_clr = 1'b1;
      @(negedge clk);
      key_clr = 1'b0;
`ifdef ARK_ZEROIZE_EN
      for (int c = 0; c < 20; c++) begin
         if (!busy) break;
         cnt++;
         checks++;
         if (dif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_ready[%0d]: got %b expected 0", c, dif.in_ready);
         end
         key_wr_en   = (c == 3);
         key_clr     = (c == 3);
         key_wr_idx  = 4'd2;
         key_wr_data = NEWK;
         @(negedge clk);
      end
      key_wr_en = 1'b0;
      key_clr   = 1'b0;
      checks++;
      if (cnt != NR + 1) begin
         errors++;
         $display("FAIL busy_cycles: got %0d expected %0d", cnt, NR + 1);
      end
`else
      for (int c = 0; c < 12; c++) begin
         if (busy) cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != 0) begin
         errors++;
         $display("FAIL busy_cycles: got %0d expected 0", cnt);
      end
`endif
      checks++;
      if (keys_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_keys_ready: got %b expected 0", keys_ready);
      end
      dif.in_valid = 1'b1;
      for (int i = 0; i <= NR; i++) begin
         dif.in_round = 4'(i);
         dif.in_state = mk_state(i);
         @(negedge clk);
`ifdef ARK_ZEROIZE_EN
         kexp = '0;
`else
         kexp = (i == 5) ? NEWK : mk_key(i);
`endif
         checks++;
         if (dif.out_state !== (mk_state(i) ^ kexp) || err_round !== 1'b1) begin
            errors++;
            $display("FAIL clr_read[%0d]: got err=%b %h expected err=1 %h", i,
                     err_round, dif.out_state, mk_state(i) ^ kexp);
         end
      end
      dif.in_valid = 1'b0;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      write_key(0, mk_key(7));
      dif.out_ready = 1'b0;
      dif.in_valid  = 1'b1;
      dif.in_round  = 4'd3;
      dif.in_state  = mk_state(3);
      @(negedge clk);
      dif.in_valid = 1'b0;
      checks++;
      if (dif.out_valid !== 1'b1 || err_round !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got v=%b err=%b expected 1/1", dif.out_valid, err_round);
      end
      key_clr = 1'b1;
      @(negedge clk);
      key_clr = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dif.in_ready, dif.out_valid, dif.out_round, err_round, busy, keys_ready} !== 9'd0 ||
          dif.out_state !== '0) begin
         errors++;
         $display("FAIL async_reset: got %b %h expected 0",
                  {dif.in_ready, dif.out_valid, dif.out_round, err_round, busy, keys_ready}, dif.out_state);
      end
      dif.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (dif.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_ready_before_edge: got %b expected 0", dif.in_ready);
      end
      @(negedge clk);
      checks++;
      if (dif.in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_ready_after_edge: got rdy=%b busy=%b expected 1/0", dif.in_ready, busy);
      end
      dif.in_valid = 1'b1;
      dif.in_round = 4'd0;
      dif.in_state = mk_state(9);
      @(negedge clk);
      dif.in_valid = 1'b0;
      checks++;
      if (dif.out_state !== mk_state(9) || err_round !== 1'b1) begin
         errors++;
         $display("FAIL bank_reset: got err=%b %h expected err=1 %h", err_round, dif.out_state, mk_state(9));
      end
   endtask

   initial begin
      dif.in_valid  = 1'b0;
      dif.in_round  = 4'd0;
      dif.in_state  = '0;
      dif.out_ready = 1'b1;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_bad_round();
      test_same_cycle();
      test_zeroize();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/round_key_store_xor.md
ROUND_KEY_STORE_XOR -- requirements
Module: round_key_store_xor

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; legal values 10, 12 and 14; key bank depth is NR+1.
REQ-002 Parameter DATA_W, default 128, state and round-key width in bits.
REQ-003 Port clk, input, 1, single clock; all logic rising-edge.
REQ-004 Port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 Key write ports, all inputs: key_wr_en (1), key_wr_idx (4), key_wr_data (DATA_W); they write one round key.
REQ-006 Port key_clr, input, 1, single-cycle request to invalidate the key bank.
REQ-007 Port keys_ready, output, 1; high when all NR+1 entries are loaded and the block is not busy.
REQ-008 Port busy, output, 1; high while zeroize is in progress.
REQ-009 Input-side ports: in_valid (input, 1), in_ready (output, 1), in_state (input, DATA_W) and in_round (input, 4).
REQ-010 Output-side ports: out_valid (output, 1), out_ready (input, 1), out_state (output, DATA_W) and out_round (output, 4).
REQ-011 Port err_round, output, 1, sticky error flag; port err_clr, input, 1, clears it.

Function
REQ-012 Key bank: NR+1 entries of DATA_W plus a loaded bitmap; a write when key_wr_en=1 and key_wr_idx<=NR stores data and sets the bit; writes with idx>NR are ignored.
REQ-013 Datapath: one register stage; a transfer occurs when in_valid&&in_ready; next cycle out_valid=1, out_state=in_state^bank[in_round], out_round=in_round.
REQ-014 in_ready = !busy && (!out_valid || out_ready); the output holds stable while out_valid&&!out_ready.
REQ-015 Back-to-back transfers sustain 1 per cycle when out_ready=1; out_valid drops the cycle after a drain with no new input.
REQ-016 If in_round>NR: out_state=in_state unmodified and err_round set on the accepting cycle.
REQ-017 If the entry for in_round is not loaded: XOR uses the stored value and sets err_round.
REQ-018 Key write and datapath read of the same index in one cycle: the read uses the old key; the new key applies from the next cycle.
REQ-019 err_clr clears err_round; a simultaneous set wins over clear.
REQ-020 FSM states: IDLE and ZERO; IDLE->ZERO on key_clr (macro on); ZERO->IDLE after the final entry is cleared.
REQ-021 key_clr during ZERO is ignored.
REQ-022 Key writes during ZERO are ignored.
REQ-023 An output already in out_valid completes normally during ZERO.

Reset
REQ-024 On rst_n low: all bank entries are 0; the bitmap is 0; FSM is IDLE.
REQ-025 On rst_n low: out_valid=0, out_state=0, out_round=0, err_round=0, busy=0, keys_ready=0.
REQ-026 While rst_n is low, in_ready=0; in_ready=1 from the first clock edge after release.
REQ-027 Reset mid-operation discards any pending output and aborts zeroize immediately.

Configuration
REQ-028 Macro ARK_ZEROIZE_EN defined: key_clr enters ZERO, writes 0 to one entry per cycle from index 0 up, clears the bitmap, busy=1 for exactly NR+1 cycles, then returns to IDLE.
REQ-029 Macro ARK_ZEROIZE_EN undefined: key_clr clears the bitmap in one cycle, key data is retained, busy stays 0, and ZERO is never entered.

Verification
REQ-030 Load idx0=000102030405060708090a0b0c0d0e0f; in_state=00112233445566778899aabbccddeeff with round 0 -> next cycle out_state=00102030405060708090a0b0c0d0e0f0, out_round=0.
REQ-031 Load all 11 entries -> keys_ready=1; stream rounds 0..10 with out_ready=1 -> 11 outputs on consecutive cycles, each XOR-correct.
REQ-032 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_state stable; release -> transfers resume with no loss or duplication.
REQ-033 in_round=11 with NR=10 -> out_state=in_state and err_round=1; pulse err_clr -> err_round=0.
REQ-034 ARK_ZEROIZE_EN defined, key_clr pulse -> busy=1 for 11 cycles, in_ready=0, writes ignored, then all entries read 0 and keys_ready=0; macro undefined -> busy stays 0 and old keys remain readable.
REQ-035 Assert rst_n low while out_valid=1 and in ZERO -> all outputs reach their reset values asynchronously.
